// File: rtl/conv1_calc.sv
// conv1_calc: 5x5 single-channel convolution stage with double-buffered kernel/bias, 4-cycle fixed latency.
// Optional macro CONV1_CALC_RELU_EN clamps negative results to zero in the output stage.
module conv1_calc #(
  parameter int DATA_BITS = 8,
  parameter int OUT_BITS  = 12,
  parameter int SHIFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [25*DATA_BITS-1:0]    data_in,
  input  logic                       w_load,
  input  logic [DATA_BITS-1:0]       w_data,
  output logic                       weights_ready,
  output logic signed [OUT_BITS-1:0] data_out,
  output logic                       valid_out
);
  localparam int PW = 2*DATA_BITS + 1;
  localparam int RW = PW + 3;
  localparam int AW = 2*DATA_BITS + 6;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 <<< (OUT_BITS-1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 <<< (OUT_BITS-1)));

  logic signed [DATA_BITS-1:0] shadow_w_q [25], shadow_w_d [25];
  logic signed [DATA_BITS-1:0] active_w_q [25], active_w_d [25];
  logic signed [DATA_BITS-1:0] shadow_b_q, shadow_b_d, active_b_q, active_b_d;
  logic signed [DATA_BITS-1:0] bias_s1_q, bias_s1_d, bias_s2_q, bias_s2_d;
  logic [4:0]                  w_cnt_q, w_cnt_d;
  logic                        commit_q, commit_d;
  logic                        weights_ready_q, weights_ready_d;

  logic signed [PW-1:0]        prod_q [25], prod_d [25];
  logic signed [RW-1:0]        row_q [5], row_d [5];
  logic signed [AW-1:0]        acc_q, acc_d;
  logic signed [AW-1:0]        shifted, sat;
  logic signed [OUT_BITS-1:0]  data_out_q, data_out_d;
  logic [3:0]                  vld_q, vld_d;

  // Shadow bank fills word by word; the active bank only changes one cycle after a full set lands.
  always_comb begin
    shadow_w_d      = shadow_w_q;
    shadow_b_d      = shadow_b_q;
    active_w_d      = active_w_q;
    active_b_d      = active_b_q;
    w_cnt_d         = w_cnt_q;
    commit_d        = 1'b0;
    weights_ready_d = weights_ready_q;
    if (w_load) begin
      if (w_cnt_q == 5'd25) begin
        shadow_b_d = w_data;
        w_cnt_d    = 5'd0;
        commit_d   = 1'b1;
      end else begin
        shadow_w_d[w_cnt_q] = w_data;
        w_cnt_d             = w_cnt_q + 5'd1;
      end
    end
    if (commit_q) begin
      active_w_d      = shadow_w_q;
      active_b_d      = shadow_b_q;
      weights_ready_d = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < 25; k++) begin
      prod_d[k] = PW'($signed({1'b0, data_in[k*DATA_BITS +: DATA_BITS]})) * PW'(active_w_q[k]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_row
      assign row_d[gi] = RW'(prod_q[5*gi])   + RW'(prod_q[5*gi+1]) + RW'(prod_q[5*gi+2])
                       + RW'(prod_q[5*gi+3]) + RW'(prod_q[5*gi+4]);
    end
  endgenerate

  // Bias travels with its window so a commit mid-flight cannot mix banks.
  always_comb begin
    bias_s1_d = active_b_q;
    bias_s2_d = bias_s1_q;
    acc_d     = AW'(bias_s2_q);
    for (int r = 0; r < 5; r++) begin
      acc_d = acc_d + AW'(row_q[r]);
    end
  end

  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > SAT_MAX)
      sat = SAT_MAX;
    else if (shifted < SAT_MIN)
      sat = SAT_MIN;
    else
      sat = shifted;
`ifdef CONV1_CALC_RELU_EN
    if (sat < 0)
      sat = '0;
`endif
    data_out_d = vld_q[2] ? OUT_BITS'(sat) : data_out_q;
    vld_d      = {vld_q[2:0], valid_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_w_q      <= '{default: '0};
      active_w_q      <= '{default: '0};
      shadow_b_q      <= '0;
      active_b_q      <= '0;
      bias_s1_q       <= '0;
      bias_s2_q       <= '0;
      w_cnt_q         <= '0;
      commit_q        <= 1'b0;
      weights_ready_q <= 1'b0;
      prod_q          <= '{default: '0};
      row_q           <= '{default: '0};
      acc_q           <= '0;
      data_out_q      <= '0;
      vld_q           <= '0;
    end else begin
      shadow_w_q      <= shadow_w_d;
      active_w_q      <= active_w_d;
      shadow_b_q      <= shadow_b_d;
      active_b_q      <= active_b_d;
      bias_s1_q       <= bias_s1_d;
      bias_s2_q       <= bias_s2_d;
      w_cnt_q         <= w_cnt_d;
      commit_q        <= commit_d;
      weights_ready_q <= weights_ready_d;
      prod_q          <= prod_d;
      row_q           <= row_d;
      acc_q           <= acc_d;
      data_out_q      <= data_out_d;
      vld_q           <= vld_d;
    end
  end

  assign weights_ready = weights_ready_q;
  assign data_out      = data_out_q;
  assign valid_out     = vld_q[3];
endmodule

// File: doc/conv1_calc.md
Name: conv1_calc

Overview:
- Single-channel 5x5 convolution arithmetic stage for conv layer 1 of the MNIST CNN.
- Sits directly downstream of the 5x5 window buffer.
- Consumes one 25-pixel window per valid cycle, multiplies it by a loadable signed kernel and adds a bias.
- Emits one scaled, saturated signed result per window through a fixed-latency pipeline with no stalls.
- The top level instantiates one copy per output channel.

Parameters:
- DATA_BITS, 8: pixel width (unsigned) and weight/bias width (signed).
- OUT_BITS, 12: output width (signed).
- SHIFT, 0: arithmetic right shift applied after the bias add, 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- valid_in  in  1  window on data_in is valid this cycle.
- data_in  in  25*DATA_BITS  flattened window. Pixel k occupies bits [k*DATA_BITS +: DATA_BITS]; k=0 is top-left, row-major.
- w_load  in  1  one kernel/bias word is presented on w_data this cycle.
- w_data  in  DATA_BITS  signed weight or bias word.
- weights_ready  out  1  at least one complete kernel+bias set has been committed.
- data_out  out  OUT_BITS  signed convolution result.
- valid_out  out  1  data_out is valid this cycle.

Behaviour:
- Reset, synchronous, active-low. Clears:
  - data_out=0, valid_out=0, weights_ready=0.
  - All pipeline valid bits=0.
  - Active and shadow weights=0, active and shadow bias=0.
  - w_cnt=0.
- Reset mid-stream flushes the pipeline: no window accepted before reset produces a valid_out after it.
- Weight load:
  - Each w_load cycle writes w_data into shadow[w_cnt], then w_cnt increments.
  - w_cnt 0..24 are kernel words k=0..24; w_cnt 25 is the bias.
  - On the cycle w_cnt==25 with w_load=1: w_cnt wraps to 0, and a commit is flagged.
  - On the next edge the entire shadow bank (25 weights + bias) is copied to the active bank and weights_ready is set to 1.
  - weights_ready stays 1 until reset.
  - A partial load never disturbs the active bank. Windows always use the active bank as it stands on the cycle they enter stage 1.
  - w_load and valid_in may be high in the same cycle with no interaction.
- Pipeline: 4 stages, no backpressure. valid_out is valid_in delayed by exactly 4 cycles. Gaps and back-to-back patterns are preserved.
  - S1: 25 products p_k = $signed({1'b0,pixel_k}) * w_k, each 2*DATA_BITS+1 bits, registered.
  - S2: 5 row partial sums of 5 products each, each widened by 3 bits, registered.
  - S3: total of the 5 row sums plus the sign-extended bias. Accumulator width 2*DATA_BITS+6 (22 bits at default), wide enough that no overflow is possible. Registered.
  - S4: arithmetic shift right by SHIFT, then saturate to [-(2^(OUT_BITS-1)), 2^(OUT_BITS-1)-1], registered into data_out.
- data_out holds its last value when valid_out=0. It is not cleared.
- valid_in is honoured even when weights_ready=0; the active bank then contains zeros, so the result is 0.
- Saturation is symmetric-range clamp. No rounding on the shift (truncate toward -inf).

Optional Feature:
- Macro CONV1_CALC_RELU_EN.
- Defined: S4 additionally clamps negative results to 0 after saturation. Output range becomes [0, 2^(OUT_BITS-1)-1]. Latency unchanged.
- Undefined: signed saturated output as above. A separate ReLU stage then follows this block.

Test Plan:
1. Load 25 weights=1, bias=0 (26 w_load pulses, then weights_ready=1). Drive one window with all pixels=10 → valid_out exactly 4 cycles later, data_out=250.
2. Kernel with only w_12=-1, bias=5. Window with pixel_12=200, others=0 → data_out=-195. With CONV1_CALC_RELU_EN defined → 0.
3. All weights=127, bias=127, all pixels=255 → internal sum 809752 → data_out=2047. All weights=-128, pixels=255 → data_out=-2048.
4. Stream 24 back-to-back windows, a 4-cycle gap, then 24 more → exactly 48 valid_out pulses with the identical gap. Each result matches a software model.
5. With kernel A active, load 20 words of kernel B while streaming → all results use A. Finish words 21..26 → windows entering S1 from the second cycle after the 26th word use B. weights_ready stays 1 throughout.
6. Assert rst_n=0 for 1 cycle while 3 windows are in flight → valid_out=0 the cycle after reset, no stale outputs, weights_ready=0, and a subsequent window yields 0 until weights are reloaded.
